shared_key_calc: RTL and testbench

SHARED_KEY_CALC -- requirements
Module: shared_key_calc

---
 rtl/shared_key_calc.sv | 135 +++++++++++++
 tb/tb_shared_key_calc.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shared_key_calc.sv
// rtl/shared_key_calc.sv - modular exponentiation key = r2^x mod p
// Left-to-right square-and-multiply over a serial interleaved modular multiplier.
module shared_key_calc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st,
  input  logic [W-1:0] r2,
  input  logic [W-1:0] x,
  input  logic [W-1:0] p,
  output logic [W-1:0] key,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, SQR, MUL, FIN} state_t;

  state_t       state, state_nx;
  logic [W-1:0] rr, rr_nx, xr, xr_nx, pr, pr_nx, res, res_nx, key_nx;
  logic [W:0]   acc, acc_nx;
  logic [CW-1:0] cyc, cyc_nx, idx, idx_nx;
  logic         errf, errf_nx, done_nx, err_nx;

  logic [W:0]   acc_in, t0, t1, t2, t3, pw;
  logic [W-1:0] md;
  logic         mbit;

  // One multiply step: double, reduce, conditionally add multiplicand, reduce.
  always_comb begin
    pw     = {1'b0, pr};
    acc_in = (cyc == LAST) ? '0 : acc;
    md     = (state == MUL) ? rr : res;
    mbit   = res[cyc];
    t0     = acc_in << 1;
    t1     = (t0 >= pw) ? t0 - pw : t0;
    t2     = t1 + (mbit ? {1'b0, md} : '0);
    t3     = (t2 >= pw) ? t2 - pw : t2;
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    xr_nx    = xr;
    pr_nx    = pr;
    res_nx   = res;
    acc_nx   = acc;
    cyc_nx   = cyc;
    idx_nx   = idx;
    errf_nx  = errf;
    key_nx   = key;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (st) begin
          rr_nx  = r2;
          xr_nx  = x;
          pr_nx  = p;
          res_nx = {{(W-1){1'b0}}, 1'b1};
          idx_nx = LAST;
          cyc_nx = LAST;
          if (p < 2 || r2 >= p) begin
            errf_nx  = 1'b1;
            state_nx = FIN;
          end else begin
            errf_nx  = 1'b0;
            state_nx = SQR;
          end
        end
      end
      SQR, MUL: begin
        acc_nx = t3;
        if (cyc != 0) begin
          cyc_nx = cyc - 1'b1;
        end else begin
          res_nx = t3[W-1:0];
          cyc_nx = LAST;
          if (state == SQR && xr[idx]) begin
            state_nx = MUL;
          end else if (idx == 0) begin
            state_nx = FIN;
          end else begin
            idx_nx   = idx - 1'b1;
            state_nx = SQR;
          end
        end
      end
      FIN: begin
        key_nx   = errf ? '0 : res;
        done_nx  = 1'b1;
        err_nx   = errf;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr    <= '0;
      xr    <= '0;
      pr    <= '0;
      res   <= '0;
      acc   <= '0;
      cyc   <= '0;
      idx   <= '0;
      errf  <= 1'b0;
      key   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      rr    <= rr_nx;
      xr    <= xr_nx;
      pr    <= pr_nx;
      res   <= res_nx;
      acc   <= acc_nx;
      cyc   <= cyc_nx;
      idx   <= idx_nx;
      errf  <= errf_nx;
      key   <= key_nx;
      done  <= done_nx;
      err   <= err_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_key_calc.sv
// tb/tb_shared_key_calc.sv - directed checks for shared_key_calc
// Latency counted in rising edges from the st-sampling edge to the edge raising done.
module tb_shared_key_calc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         st  = 1'b0;
  logic [W-1:0] r2 = '0, x = '0, p = '0;
  logic [W-1:0] key;
  logic         busy, done, err;

  int checks = 0;
  int errors = 0;

  shared_key_calc #(.W(W)) dut (
    .clk(clk), .rst(rst), .st(st), .r2(r2), .x(x), .p(p),
    .key(key), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [W-1:0] r2v, input logic [W-1:0] xv,
                        input logic [W-1:0] pv, input bit scramble,
                        output int lat, output logic [W-1:0] k, output logic e);
    @(negedge clk);
    r2 = r2v; x = xv; p = pv; st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    if (scramble) begin
      r2 = '0; x = '1; p = 32'd1;
    end
    lat = -1;
    for (int c = 1; c <= 5000; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    k = key;
    e = err;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++; if (key !== '0)  begin errors++; $display("FAIL reset_key got %0h want 0", key); end
    checks++; if (done !== 0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 0)   begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (busy !== 0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int lat; logic [W-1:0] k; logic e;
    run_op(32'd19, 32'd6, 32'd23, 1'b1, lat, k, e);
    checks++; if (lat !== 1089) begin errors++; $display("FAIL basic_latency got %0d want 1089", lat); end
    checks++; if (k !== 32'd2)  begin errors++; $display("FAIL basic_key got %0d want 2", k); end
    checks++; if (e !== 1'b0)   begin errors++; $display("FAIL basic_err got %b want 0", e); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (key !== 32'd2) begin errors++; $display("FAIL basic_key_hold got %0d want 2", key); end
  endtask

  task automatic test_peer_side;
    int lat; logic [W-1:0] k; logic e;
    run_op(32'd8, 32'd15, 32'd23, 1'b0, lat, k, e);
    checks++; if (lat !== 1153) begin errors++; $display("FAIL peer_latency got %0d want 1153", lat); end
    checks++; if (k !== 32'd2)  begin errors++; $display("FAIL peer_key got %0d want 2", k); end
  endtask

  task automatic test_full_width;
    int lat; logic [W-1:0] k; logic e;
    run_op(32'hFFFF_FFFA, 32'd2, 32'hFFFF_FFFB, 1'b0, lat, k, e);
    checks++; if (lat !== 1057) begin errors++; $display("FAIL wide_latency got %0d want 1057", lat); end
    checks++; if (k !== 32'd1)  begin errors++; $display("FAIL wide_key got %0h want 1", k); end
    run_op(32'd3, 32'd5, 32'hFFFF_FFFB, 1'b0, lat, k, e);
    checks++; if (k !== 32'd243) begin errors++; $display("FAIL wide_small_key got %0d want 243", k); end
  endtask

  task automatic test_zero_exp_and_error;
    int lat; logic [W-1:0] k; logic e;
    run_op(32'd5, 32'd0, 32'd17, 1'b0, lat, k, e);
    checks++; if (lat !== 1025) begin errors++; $display("FAIL zexp_latency got %0d want 1025", lat); end
    checks++; if (k !== 32'd1)  begin errors++; $display("FAIL zexp_key got %0d want 1", k); end
    run_op(32'd5, 32'd0, 32'd1, 1'b0, lat, k, e);
    checks++; if (lat !== 1)    begin errors++; $display("FAIL perr_latency got %0d want 1", lat); end
    checks++; if (e !== 1'b1)   begin errors++; $display("FAIL perr_err got %b want 1", e); end
    checks++; if (k !== 32'd0)  begin errors++; $display("FAIL perr_key got %0d want 0", k); end
    run_op(32'd17, 32'd3, 32'd17, 1'b0, lat, k, e);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL r2err got lat=%0d err=%b want lat=1 err=1", lat, e); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] seen;
    @(negedge clk);
    r2 = 32'd4; x = 32'd1; p = 32'd1; st = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      seen[c] = done;
    end
    st = 1'b0;
    checks++; if (seen !== 3'b101) begin errors++; $display("FAIL b2b_done_pattern got %b want 101", seen); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_abort;
    int lat; logic [W-1:0] k; logic e;
    bit seen_done;
    seen_done = 0;
    @(negedge clk);
    r2 = 32'd6; x = 32'd3; p = 32'd17; st = 1'b1;
    @(posedge clk);
    #1 st = 1'b0;
    for (int c = 1; c <= 500; c++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
      if (c == 99)  begin st = 1'b1; r2 = 32'd2; x = 32'd1; p = 32'd5; end
      if (c == 100) st = 1'b0;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", seen_done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (key !== '0 || busy !== 0 || done !== 0 || err !== 0) begin
      errors++; $display("FAIL abort_async_outputs got key=%0h busy=%b done=%b err=%b want all 0", key, busy, done, err);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (key !== '0 || busy !== 0 || done !== 0) begin
      errors++; $display("FAIL abort_held_outputs got key=%0h busy=%b done=%b want all 0", key, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    run_op(32'd6, 32'd3, 32'd17, 1'b0, lat, k, e);
    checks++; if (lat !== 1089) begin errors++; $display("FAIL restart_latency got %0d want 1089", lat); end
    checks++; if (k !== 32'd12) begin errors++; $display("FAIL restart_key got %0d want 12", k); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_peer_side;
    test_full_width;
    test_zero_exp_and_error;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
